// File: rtl/bc_polinomio.sv
// Control block for the Horner-form polynomial datapath: ((A*X)+B)*X + C on one shared ALU.
// Optional sticky overflow flag (erro) is built only when BC_OVF_EN is defined.
module bc_polinomio #(
   parameter int MUL_LAT = 1
) (
   input  logic       ck,
   input  logic       rst,
   input  logic       inicio,
   input  logic       ovf,
   output logic       pronto,
   output logic       ocupado,
   output logic       ld_ent,
   output logic       sel_a,
   output logic [1:0] sel_b,
   output logic       op,
   output logic       ld_acc,
   output logic       ld_res,
   output logic       erro
);

   // state | meaning
   // IDLE  | waiting for inicio
   // LOAD  | BO captures X, A, B, C
   // MUL1  | ACC <= RA * RX, held MUL_LAT cycles
   // ADD1  | ACC <= ACC + RB
   // MUL2  | ACC <= ACC * RX, held MUL_LAT cycles
   // ADD2  | Resultado <= ACC + RC
   // DONE  | pronto high until inicio drops
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      MUL1 = 3'd2,
      ADD1 = 3'd3,
      MUL2 = 3'd4,
      ADD2 = 3'd5,
      DONE = 3'd6
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

   generate
      if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
         $error("bc_polinomio: MUL_LAT must be in 1..15");
      end
   endgenerate

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       in_mul;
   logic       cnt_last;

   assign in_mul   = (state_q == MUL1) || (state_q == MUL2);
   assign cnt_last = (cnt_q == CNT_LAST);

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (inicio) state_d = LOAD;
         LOAD:    state_d = MUL1;
         MUL1:    if (cnt_last) state_d = ADD1;
         ADD1:    state_d = MUL2;
         MUL2:    if (cnt_last) state_d = ADD2;
         ADD2:    state_d = DONE;
         DONE:    if (!inicio) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counter runs only while a MUL step is held; any other cycle leaves it at 0 for the next entry.
   always_comb begin
      cnt_d = '0;
      if (in_mul && !cnt_last) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_comb begin
      pronto  = 1'b0;
      ocupado = 1'b0;
      ld_ent  = 1'b0;
      sel_a   = 1'b0;
      sel_b   = 2'b00;
      op      = 1'b0;
      ld_acc  = 1'b0;
      ld_res  = 1'b0;
      case (state_q)
         LOAD: begin
            ocupado = 1'b1;
            ld_ent  = 1'b1;
         end
         MUL1: begin
            ocupado = 1'b1;
            op      = 1'b1;
            ld_acc  = cnt_last;
         end
         ADD1: begin
            ocupado = 1'b1;
            sel_a   = 1'b1;
            sel_b   = 2'b01;
            ld_acc  = 1'b1;
         end
         MUL2: begin
            ocupado = 1'b1;
            sel_a   = 1'b1;
            op      = 1'b1;
            ld_acc  = cnt_last;
         end
         ADD2: begin
            ocupado = 1'b1;
            sel_a   = 1'b1;
            sel_b   = 2'b10;
            ld_res  = 1'b1;
         end
         DONE: begin
            pronto  = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef BC_OVF_EN
   logic erro_q;

   // Cleared on acceptance; that cycle never loads ACC or Resultado, so no set/clear conflict.
   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         erro_q <= 1'b0;
      end else if (state_q == IDLE && inicio) begin
         erro_q <= 1'b0;
      end else if ((ld_acc || ld_res) && ovf) begin
         erro_q <= 1'b1;
      end
   end

   assign erro = erro_q;
`else
   logic unused_ovf;

   assign unused_ovf = ovf;
   assign erro       = 1'b0;
`endif

endmodule

// File: tb/tb_bc_polinomio.sv
// Directed bench for bc_polinomio: two instances (MUL_LAT=1 and 4), each driving a small BO model.
module tb_bc_polinomio;

`ifdef BC_OVF_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   logic ck = 1'b0;
   always #5 ck = ~ck;

   logic rst;
   int   checks   = 0;
   int   failures = 0;

   // instance with MUL_LAT = 1
   logic        inicio1, pronto1, ocupado1, ld_ent1, sel_a1, op1, ld_acc1, ld_res1, ovf1, erro1;
   logic [1:0]  sel_b1;
   logic [15:0] x1 = '0, a1 = '0, b1 = '0, c1 = '0;
   logic [15:0] rx1 = '0, ra1 = '0, rb1 = '0, rc1 = '0, acc1 = '0, res1 = '0;
   logic [16:0] alu1;
   logic [8:0]  o1;

   // instance with MUL_LAT = 4
   logic        inicio4, pronto4, ocupado4, ld_ent4, sel_a4, op4, ld_acc4, ld_res4, ovf4, erro4;
   logic [1:0]  sel_b4;
   logic [15:0] x4 = '0, a4 = '0, b4 = '0, c4 = '0;
   logic [15:0] rx4 = '0, ra4 = '0, rb4 = '0, rc4 = '0, acc4 = '0, res4 = '0;
   logic [16:0] alu4;
   logic [8:0]  o4;

   bc_polinomio #(.MUL_LAT(1)) dut1 (
      .ck(ck), .rst(rst), .inicio(inicio1), .ovf(ovf1), .pronto(pronto1), .ocupado(ocupado1),
      .ld_ent(ld_ent1), .sel_a(sel_a1), .sel_b(sel_b1), .op(op1), .ld_acc(ld_acc1),
      .ld_res(ld_res1), .erro(erro1)
   );

   bc_polinomio #(.MUL_LAT(4)) dut4 (
      .ck(ck), .rst(rst), .inicio(inicio4), .ovf(ovf4), .pronto(pronto4), .ocupado(ocupado4),
      .ld_ent(ld_ent4), .sel_a(sel_a4), .sel_b(sel_b4), .op(op4), .ld_acc(ld_acc4),
      .ld_res(ld_res4), .erro(erro4)
   );

   // returns {overflow, 16-bit result}
   function automatic logic [16:0] alu(input logic sa, input logic [1:0] sb, input logic o,
                                       input logic [15:0] ra, input logic [15:0] rx,
                                       input logic [15:0] rb, input logic [15:0] rc,
                                       input logic [15:0] acc);
      logic [15:0] opa;
      logic [15:0] opb;
      logic [31:0] p;
      logic [16:0] s;
      opa = sa ? acc : ra;
      case (sb)
         2'b00:   opb = rx;
         2'b01:   opb = rb;
         2'b10:   opb = rc;
         default: opb = 16'h0000;
      endcase
      p = 32'(opa) * 32'(opb);
      s = {1'b0, opa} + {1'b0, opb};
      return o ? {|p[31:16], p[15:0]} : s;
   endfunction

   assign alu1 = alu(sel_a1, sel_b1, op1, ra1, rx1, rb1, rc1, acc1);
   assign ovf1 = alu1[16];
   assign alu4 = alu(sel_a4, sel_b4, op4, ra4, rx4, rb4, rc4, acc4);
   assign ovf4 = alu4[16];

   assign o1 = {pronto1, ocupado1, ld_ent1, sel_a1, sel_b1, op1, ld_acc1, ld_res1};
   assign o4 = {pronto4, ocupado4, ld_ent4, sel_a4, sel_b4, op4, ld_acc4, ld_res4};

   always @(posedge ck) begin
      if (ld_ent1) begin
         rx1 <= x1; ra1 <= a1; rb1 <= b1; rc1 <= c1;
      end
      if (ld_acc1) acc1 <= alu1[15:0];
      if (ld_res1) res1 <= alu1[15:0];
      if (ld_ent4) begin
         rx4 <= x4; ra4 <= a4; rb4 <= b4; rc4 <= c4;
      end
      if (ld_acc4) acc4 <= alu4[15:0];
      if (ld_res4) res4 <= alu4[15:0];
   end

   // Expected {pronto,ocupado,ld_ent,sel_a,sel_b,op,ld_acc,ld_res} k cycles after the accept edge.
   function automatic logic [8:0] exp_out(input int k, input int l);
      if (k == 0)                      return 9'b011000000;
      if (k >= 1 && k < l)             return 9'b010000100;
      if (k == l)                      return 9'b010000110;
      if (k == l + 1)                  return 9'b010101010;
      if (k >= l + 2 && k < 2 * l + 1) return 9'b010100100;
      if (k == 2 * l + 1)              return 9'b010100110;
      if (k == 2 * l + 2)              return 9'b010110001;
      if (k == 2 * l + 3)              return 9'b100000000;
      return 9'b000000000;
   endfunction

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; inicio1 = 1'b0; inicio4 = 1'b0;
      step(); step();
      checks++;
      if (o1 !== 9'd0 || o4 !== 9'd0) begin
         failures++;
         $display("FAIL reset_outputs got1=%b got4=%b exp=000000000", o1, o4);
      end
      checks++;
      if (erro1 !== 1'b0 || erro4 !== 1'b0) begin
         failures++;
         $display("FAIL reset_erro got1=%b got4=%b exp=0", erro1, erro4);
      end
      rst = 1'b1;
      step(); step();
      checks++;
      if (o1 !== 9'd0) begin
         failures++;
         $display("FAIL reset_idle_after_release got=%b exp=000000000", o1);
      end
   endtask

   // Leaves inicio1 high with dut1 in DONE.
   task automatic test_nominal();
      x1 = 16'd2; a1 = 16'd3; b1 = 16'd4; c1 = 16'd5;
      inicio1 = 1'b1;
      step();
      for (int k = 0; k <= 5; k++) begin
         checks++;
         if (o1 !== exp_out(k, 1)) begin
            failures++;
            $display("FAIL nominal_seq k=%0d got=%b exp=%b", k, o1, exp_out(k, 1));
         end
         if (k < 5) step();
      end
      checks++;
      if (res1 !== 16'h0019) begin
         failures++;
         $display("FAIL nominal_result got=%h exp=0019", res1);
      end
   endtask

   task automatic test_handshake();
      int ld_seen;
      int pr_low;
      ld_seen = 0; pr_low = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ld_ent1) ld_seen++;
         if (!pronto1) pr_low++;
      end
      checks++;
      if (ld_seen !== 0 || pr_low !== 0) begin
         failures++;
         $display("FAIL hold_no_restart ld_ent_count=%0d pronto_low_cycles=%0d exp=0,0", ld_seen, pr_low);
      end
      inicio1 = 1'b0;
      step();
      checks++;
      if (o1 !== 9'd0) begin
         failures++;
         $display("FAIL handshake_release got=%b exp=000000000", o1);
      end
      x1 = 16'd1; a1 = 16'd1; b1 = 16'd1; c1 = 16'd1;
      inicio1 = 1'b1;
      step();
      for (int k = 0; k <= 5; k++) begin
         checks++;
         if (o1 !== exp_out(k, 1)) begin
            failures++;
            $display("FAIL restart_seq k=%0d got=%b exp=%b", k, o1, exp_out(k, 1));
         end
         if (k < 5) step();
      end
      checks++;
      if (res1 !== 16'd3) begin
         failures++;
         $display("FAIL restart_result got=%h exp=0003", res1);
      end
      inicio1 = 1'b0;
      step();
   endtask

   task automatic test_mullat4();
      x4 = 16'h0010; a4 = 16'h0001; b4 = 16'h0000; c4 = 16'h0007;
      inicio4 = 1'b1;
      step();
      for (int k = 0; k <= 11; k++) begin
         checks++;
         if (o4 !== exp_out(k, 4)) begin
            failures++;
            $display("FAIL mullat4_seq k=%0d got=%b exp=%b", k, o4, exp_out(k, 4));
         end
         if (k < 11) step();
      end
      checks++;
      if (res4 !== 16'h0107) begin
         failures++;
         $display("FAIL mullat4_result got=%h exp=0107", res4);
      end
      inicio4 = 1'b0;
      step();
      checks++;
      if (o4 !== 9'd0) begin
         failures++;
         $display("FAIL mullat4_idle got=%b exp=000000000", o4);
      end
   endtask

   task automatic test_pulse();
      int pc;
      pc = 0;
      x1 = 16'd2; a1 = 16'd3; b1 = 16'd4; c1 = 16'd5;
      inicio1 = 1'b1;
      step();
      inicio1 = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (pronto1) pc++;
         step();
      end
      checks++;
      if (pc !== 1) begin
         failures++;
         $display("FAIL pulse_pronto_cycles got=%0d exp=1", pc);
      end
      checks++;
      if (o1 !== 9'd0 || res1 !== 16'h0019) begin
         failures++;
         $display("FAIL pulse_end got=%b res=%h exp=000000000 res=0019", o1, res1);
      end
   endtask

   task automatic test_ovf();
      x1 = 16'h0100; a1 = 16'h0100; b1 = 16'h0000; c1 = 16'h0000;
      inicio1 = 1'b1;
      step();
      step();
      checks++;
      if (erro1 !== 1'b0) begin
         failures++;
         $display("FAIL ovf_before_load got=%b exp=0", erro1);
      end
      step();
      checks++;
      if (erro1 !== OVF_EN) begin
         failures++;
         $display("FAIL ovf_at_mul1_load got=%b exp=%b", erro1, OVF_EN);
      end
      step(); step(); step();
      checks++;
      if (erro1 !== OVF_EN || pronto1 !== 1'b1) begin
         failures++;
         $display("FAIL ovf_at_done erro=%b pronto=%b exp=%b,1", erro1, pronto1, OVF_EN);
      end
      inicio1 = 1'b0;
      step();
      checks++;
      if (erro1 !== OVF_EN) begin
         failures++;
         $display("FAIL ovf_sticky_idle got=%b exp=%b", erro1, OVF_EN);
      end
      x1 = 16'd2; a1 = 16'd3; b1 = 16'd4; c1 = 16'd5;
      inicio1 = 1'b1;
      step();
      checks++;
      if (erro1 !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear_on_accept got=%b exp=0", erro1);
      end
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (erro1 !== 1'b0 || pronto1 !== 1'b1 || res1 !== 16'h0019) begin
         failures++;
         $display("FAIL ovf_clean_run erro=%b pronto=%b res=%h exp=0,1,0019", erro1, pronto1, res1);
      end
      inicio1 = 1'b0;
      step();
   endtask

   task automatic test_reset_midrun();
      int bad;
      bad = 0;
      x1 = 16'd2; a1 = 16'd3; b1 = 16'd4; c1 = 16'd5;
      inicio1 = 1'b1;
      step();
      step(); step(); step();
      checks++;
      if (o1 !== exp_out(3, 1)) begin
         failures++;
         $display("FAIL midrun_in_mul2 got=%b exp=%b", o1, exp_out(3, 1));
      end
      rst = 1'b0;
      #1;
      checks++;
      if (o1 !== 9'd0 || erro1 !== 1'b0) begin
         failures++;
         $display("FAIL midrun_async_reset got=%b erro=%b exp=000000000,0", o1, erro1);
      end
      inicio1 = 1'b0;
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (o1 !== 9'd0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL midrun_stays_idle bad_cycles=%0d exp=0", bad);
      end
      inicio1 = 1'b1;
      step();
      checks++;
      if (o1 !== exp_out(0, 1)) begin
         failures++;
         $display("FAIL midrun_restart got=%b exp=%b", o1, exp_out(0, 1));
      end
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (pronto1 !== 1'b1 || res1 !== 16'h0019) begin
         failures++;
         $display("FAIL midrun_complete pronto=%b res=%h exp=1,0019", pronto1, res1);
      end
      inicio1 = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_handshake();
      test_mullat4();
      test_pulse();
      test_ovf();
      test_reset_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
